// File: rtl/piso_serial_tx_controller.sv
// piso_serial_tx_controller
// Sequences one PISO shift register: accepts parallel words over valid/ready,
// issues Load then DATA_WIDTH Shift-phase cycles (MSB first), marks frame
// boundaries, counts completed words and inserts GAP_CYCLES idle cycles
// between words. Enable_In low freezes every register and silences strobes.
module piso_serial_tx_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Data_Valid_In,
  output logic                  Data_Ready_Out,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  output logic                  PISO_Enable_Out,
  output logic                  PISO_Load_Out,
  output logic                  PISO_Shift_Out,
  output logic [DATA_WIDTH-1:0] PISO_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Frame_Start_Out,
  output logic                  Frame_End_Out,
  output logic                  Busy_Out,
  output logic [15:0]           Word_Count_Out
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
  // Unused when GAP_CYCLES is 0, since GAP is then never entered.
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           word_cnt_q, word_cnt_d;

  // State and datapath registers; reset wins over enable, enable low holds all.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= 8'd0;
      data_q     <= '0;
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next-state and counter updates; everything holds while disabled.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    data_d     = data_q;
    word_cnt_d = word_cnt_q;
    if (Enable_In) begin
      case (state_q)
        ST_IDLE: begin
          // Ready equals Enable_In here, so a valid word is a handshake.
          if (Data_Valid_In) begin
            data_d  = Parallel_Data_In;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
        ST_SHIFT: begin
          if (bit_cnt_q == BIT_LAST) begin
            word_cnt_d = word_cnt_q + 16'd1;
            if (GAP_CYCLES > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = 8'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Moore output decode from registered state; strobes forced low when disabled.
  always_comb begin
    Data_Ready_Out   = 1'b0;
    PISO_Load_Out    = 1'b0;
    PISO_Shift_Out   = 1'b0;
    Serial_Valid_Out = 1'b0;
    Frame_Start_Out  = 1'b0;
    Frame_End_Out    = 1'b0;
    if (Enable_In) begin
      case (state_q)
        ST_IDLE: begin
          // Held low while reset is asserted so no word is taken at a reset edge.
          Data_Ready_Out = ~Reset_In;
        end
        ST_LOAD: begin
          PISO_Load_Out = 1'b1;
        end
        ST_SHIFT: begin
          Serial_Valid_Out = 1'b1;
          Frame_Start_Out  = (bit_cnt_q == '0);
          Frame_End_Out    = (bit_cnt_q == BIT_LAST);
          PISO_Shift_Out   = (bit_cnt_q != BIT_LAST);
        end
        ST_GAP: begin
          Data_Ready_Out = 1'b0;
        end
        default: begin
          Data_Ready_Out = 1'b0;
        end
      endcase
    end else begin
      Data_Ready_Out = 1'b0;
    end
  end

  assign PISO_Enable_Out = Enable_In;
  assign PISO_Data_Out   = data_q;
  assign Busy_Out        = (state_q != ST_IDLE);
  assign Word_Count_Out  = word_cnt_q;

endmodule

// File: tb/tb_piso_serial_tx_controller.sv
// Directed bench for piso_serial_tx_controller: two instances (gap 0 and
// gap 3) share stimulus; each drives a small behavioural PISO so the serial
// stream can be checked bit by bit against hand-computed words.
module tb_piso_serial_tx_controller;

  logic        clk = 1'b0;
  logic        rst, en, valid;
  logic [15:0] pdata;

  logic        r0, pen0, ld0, sh0, sv0, fs0, fe0, bz0;
  logic [15:0] pd0, wc0;
  logic        r3, pen3, ld3, sh3, sv3, fs3, fe3, bz3;
  logic [15:0] pd3, wc3;

  logic [15:0] sr0, sr3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serial_tx_controller #(.DATA_WIDTH(16), .GAP_CYCLES(0)) dut0 (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Data_Valid_In(valid),
    .Data_Ready_Out(r0), .Parallel_Data_In(pdata), .PISO_Enable_Out(pen0),
    .PISO_Load_Out(ld0), .PISO_Shift_Out(sh0), .PISO_Data_Out(pd0),
    .Serial_Valid_Out(sv0), .Frame_Start_Out(fs0), .Frame_End_Out(fe0),
    .Busy_Out(bz0), .Word_Count_Out(wc0)
  );

  piso_serial_tx_controller #(.DATA_WIDTH(16), .GAP_CYCLES(3)) dut3 (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Data_Valid_In(valid),
    .Data_Ready_Out(r3), .Parallel_Data_In(pdata), .PISO_Enable_Out(pen3),
    .PISO_Load_Out(ld3), .PISO_Shift_Out(sh3), .PISO_Data_Out(pd3),
    .Serial_Valid_Out(sv3), .Frame_Start_Out(fs3), .Frame_End_Out(fe3),
    .Busy_Out(bz3), .Word_Count_Out(wc3)
  );

  // Behavioural PISO attached to the gap-0 controller; MSB is the serial bit.
  always @(posedge clk) begin
    if (rst) sr0 <= 16'h0000;
    else if (pen0) begin
      if (ld0) sr0 <= pd0;
      else if (sh0) sr0 <= {sr0[14:0], 1'b0};
    end
  end

  // Behavioural PISO attached to the gap-3 controller.
  always @(posedge clk) begin
    if (rst) sr3 <= 16'h0000;
    else if (pen3) begin
      if (ld3) sr3 <= pd3;
      else if (sh3) sr3 <= {sr3[14:0], 1'b0};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b1; valid = 1'b0; pdata = 16'h0000;
    tick; tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; valid = 1'b1; pdata = 16'h1111;
    tick;
    total++;
    if ({ld0, sh0, sv0, fs0, fe0, bz0, r0} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", {ld0, sh0, sv0, fs0, fe0, bz0, r0}, 7'b0);
    end
    total++;
    if (wc0 !== 16'h0000 || pd0 !== 16'h0000) begin
      bad++; $display("FAIL reset_regs wc=%h pd=%h exp=0000/0000", wc0, pd0);
    end
    valid = 1'b0; rst = 1'b0;
    tick;
    total++;
    if (r0 !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%b exp=1", r0); end
    // Start a word and reset it at bit 5.
    pdata = 16'hA5C3; valid = 1'b1;
    tick;
    valid = 1'b0;
    total++;
    if (ld0 !== 1'b1) begin bad++; $display("FAIL midword_load got=%b exp=1", ld0); end
    repeat (6) tick;
    total++;
    if (sv0 !== 1'b1 || fs0 !== 1'b0 || bz0 !== 1'b1) begin
      bad++; $display("FAIL midword_bit5 sv=%b fs=%b bz=%b exp=1/0/1", sv0, fs0, bz0);
    end
    rst = 1'b1;
    tick;
    total++;
    if ({ld0, sh0, sv0, fs0, fe0, bz0, r0} !== 7'b0 || wc0 !== 16'h0000 || pd0 !== 16'h0000) begin
      bad++; $display("FAIL midword_reset got=%b wc=%h pd=%h exp=0000000/0000/0000",
                      {ld0, sh0, sv0, fs0, fe0, bz0, r0}, wc0, pd0);
    end
    rst = 1'b0;
    tick;
    total++;
    if (r0 !== 1'b1 || bz0 !== 1'b0) begin
      bad++; $display("FAIL midword_release ready=%b busy=%b exp=1/0", r0, bz0);
    end
    repeat (3) tick;
    total++;
    if (sv0 !== 1'b0 || wc0 !== 16'h0000) begin
      bad++; $display("FAIL midword_discard sv=%b wc=%h exp=0/0000", sv0, wc0);
    end
  endtask

  task automatic test_single_word;
    logic [15:0] got;
    int          shifts;
    got = 16'h0000; shifts = 0;
    do_reset;
    pdata = 16'hB2F1; valid = 1'b1;
    tick;
    valid = 1'b0;
    total++;
    if (ld0 !== 1'b1 || sv0 !== 1'b0) begin
      bad++; $display("FAIL single_load ld=%b sv=%b exp=1/0", ld0, sv0);
    end
    for (int i = 0; i < 16; i++) begin
      tick;
      got = {got[14:0], sr0[15]};
      if (sh0 === 1'b1) shifts++;
      total++;
      if ({sv0, fs0, fe0, sh0, ld0, r0} !== {1'b1, (i == 0), (i == 15), (i < 15), 1'b0, 1'b0}) begin
        bad++; $display("FAIL single_strobes bit=%0d got=%b exp=%b", i, {sv0, fs0, fe0, sh0, ld0, r0},
                        {1'b1, (i == 0), (i == 15), (i < 15), 1'b0, 1'b0});
      end
    end
    tick;
    total++;
    if (got !== 16'hB2F1) begin bad++; $display("FAIL single_stream got=%h exp=b2f1", got); end
    total++;
    if (shifts !== 15) begin bad++; $display("FAIL single_shift_count got=%0d exp=15", shifts); end
    total++;
    if (sv0 !== 1'b0 || r0 !== 1'b1 || bz0 !== 1'b0 || wc0 !== 16'd1) begin
      bad++; $display("FAIL single_done sv=%b ready=%b busy=%b wc=%h exp=0/1/0/0001", sv0, r0, bz0, wc0);
    end
    tick;
    total++;
    if (r0 !== 1'b1 || pd0 !== 16'hB2F1) begin
      bad++; $display("FAIL single_ready19 ready=%b pd=%h exp=1/b2f1", r0, pd0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] stream;
    int          nbits, loads, t1, t2, hs, nfs, nfe, nsh;
    stream = 32'h0; nbits = 0; loads = 0; t1 = 0; t2 = 0; hs = 0; nfs = 0; nfe = 0; nsh = 0;
    do_reset;
    pdata = 16'hFFFF; valid = 1'b1;
    #1;
    if (valid && r3) hs++;
    for (int n = 1; n <= 60; n++) begin
      tick;
      if (ld3) begin
        loads++;
        if (loads == 1) begin t1 = n; pdata = 16'h0001; end
        else begin t2 = n; valid = 1'b0; end
      end
      if (sv3) begin stream = {stream[30:0], sr3[15]}; nbits++; end
      if (fs3) nfs++;
      if (fe3) nfe++;
      if (sh3) nsh++;
      if (valid && r3) hs++;
    end
    total++;
    if (t2 - t1 !== 21) begin bad++; $display("FAIL b2b_load_spacing got=%0d exp=21", t2 - t1); end
    total++;
    if (hs !== 2) begin bad++; $display("FAIL b2b_handshakes got=%0d exp=2", hs); end
    total++;
    if (nbits !== 32 || stream !== {16'hFFFF, 16'h0001}) begin
      bad++; $display("FAIL b2b_stream bits=%0d got=%h exp=32/ffff0001", nbits, stream);
    end
    total++;
    if (nfs !== 2 || nfe !== 2 || nsh !== 30) begin
      bad++; $display("FAIL b2b_markers fs=%0d fe=%0d sh=%0d exp=2/2/30", nfs, nfe, nsh);
    end
    total++;
    if (wc3 !== 16'd2 || pd3 !== 16'h0001 || bz3 !== 1'b0 || pen3 !== 1'b1) begin
      bad++; $display("FAIL b2b_end wc=%h pd=%h busy=%b pen=%b exp=0002/0001/0/1", wc3, pd3, bz3, pen3);
    end
  endtask

  task automatic test_enable_pause;
    logic [15:0] got;
    int          nget;
    got = 16'h0000; nget = 0;
    do_reset;
    pdata = 16'h8001; valid = 1'b1;
    tick;
    valid = 1'b0;
    repeat (7) begin
      tick;
      if (sv0) begin got = {got[14:0], sr0[15]}; nget++; end
    end
    tick;
    en = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick;
      total++;
      if ({sv0, fs0, fe0, sh0, ld0, r0, pen0} !== 7'b0 || bz0 !== 1'b1) begin
        bad++; $display("FAIL pause_strobes cyc=%0d got=%b busy=%b exp=0000000/1", k,
                        {sv0, fs0, fe0, sh0, ld0, r0, pen0}, bz0);
      end
    end
    en = 1'b1;
    #1;
    for (int g = 0; g < 40 && nget < 16; g++) begin
      if (sv0) begin got = {got[14:0], sr0[15]}; nget++; end
      if (nget < 16) tick;
    end
    total++;
    if (nget !== 16 || got !== 16'h8001) begin
      bad++; $display("FAIL pause_stream bits=%0d got=%h exp=16/8001", nget, got);
    end
    tick;
    total++;
    if (sv0 !== 1'b0 || wc0 !== 16'd1) begin
      bad++; $display("FAIL pause_done sv=%b wc=%h exp=0/0001", sv0, wc0);
    end
  endtask

  task automatic test_valid_during_shift;
    int e;
    e = 0;
    do_reset;
    pdata = 16'h1234; valid = 1'b1;
    tick;
    pdata = 16'hABCD;
    for (int i = 0; i < 17; i++) begin
      if (pd0 !== 16'h1234 || r0 !== 1'b0) e++;
      tick;
    end
    total++;
    if (e !== 0) begin bad++; $display("FAIL vds_hold errors=%0d exp=0", e); end
    total++;
    if (r0 !== 1'b1 || pd0 !== 16'h1234) begin
      bad++; $display("FAIL vds_idle ready=%b pd=%h exp=1/1234", r0, pd0);
    end
    tick;
    valid = 1'b0;
    total++;
    if (pd0 !== 16'hABCD || ld0 !== 1'b1) begin
      bad++; $display("FAIL vds_accept pd=%h ld=%b exp=abcd/1", pd0, ld0);
    end
  endtask

  task automatic test_word_wrap;
    do_reset;
    force dut0.word_cnt_q = 16'hFFFF;
    tick;
    release dut0.word_cnt_q;
    #1;
    total++;
    if (wc0 !== 16'hFFFF) begin bad++; $display("FAIL wrap_preset got=%h exp=ffff", wc0); end
    pdata = 16'h5555; valid = 1'b1;
    tick;
    valid = 1'b0;
    repeat (16) tick;
    total++;
    if (wc0 !== 16'hFFFF || fe0 !== 1'b1) begin
      bad++; $display("FAIL wrap_last_bit wc=%h fe=%b exp=ffff/1", wc0, fe0);
    end
    tick;
    total++;
    if (wc0 !== 16'h0000 || bz0 !== 1'b0) begin
      bad++; $display("FAIL wrap_done wc=%h busy=%b exp=0000/0", wc0, bz0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; valid = 1'b0; pdata = 16'h0000;
    test_reset;
    test_single_word;
    test_back_to_back;
    test_enable_pause;
    test_valid_during_shift;
    test_word_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
